// File: rtl/bp_fe_pkg.sv
// Shared frontend types: the fetch-buffer entry declaration macro and default widths.
`define DECLARE_BP_FE_FETCH_BUFFER_ENTRY_S(vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p) \
  typedef struct packed { \
    logic [vaddr_width_p-1:0]               pc; \
    logic [instr_width_p-1:0]               instr; \
    logic [branch_metadata_fwd_width_p-1:0] br_metadata; \
  } bp_fe_fetch_buffer_entry_s

package bp_fe_pkg;
  localparam int bp_fe_vaddr_width_gp               = 39;
  localparam int bp_fe_instr_width_gp               = 32;
  localparam int bp_fe_branch_metadata_fwd_width_gp = 36;
  localparam int bp_fe_fetch_buffer_els_gp          = 4;
endpackage

// File: rtl/bp_fe_fetch_buffer_mem.sv
// Fetch-buffer storage: els_p x width_p registers, one synchronous write port, one asynchronous read port.
module bp_fe_fetch_buffer_mem #(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] r_mem [els_p];

  // Data carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_v_i) r_mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// In-order fetch buffer (1-cycle latency; 0 with BP_FE_FETCH_BUFFER_BYPASS_EN); fetches arriving when full
// are dropped and flagged on replay_v_o; flush_i discards everything, backend drains via valid-yumi.
module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p               = bp_fe_vaddr_width_gp,
  parameter int instr_width_p               = bp_fe_instr_width_gp,
  parameter int branch_metadata_fwd_width_p = bp_fe_branch_metadata_fwd_width_gp,
  parameter int els_p                       = bp_fe_fetch_buffer_els_gp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   fetch_v_i,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
  output logic                                   replay_v_o,
  input  logic                                   flush_i,
  output logic                                   fe_v_o,
  output logic [vaddr_width_p-1:0]               fe_pc_o,
  output logic [instr_width_p-1:0]               fe_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] fe_br_metadata_o,
  input  logic                                   fe_yumi_i,
  output logic [$clog2(els_p+1)-1:0]             count_o
);

  localparam int addr_width_lp  = $clog2(els_p);
  localparam int ptr_width_lp   = addr_width_lp + 1;
  localparam int count_width_lp = $clog2(els_p+1);

  `DECLARE_BP_FE_FETCH_BUFFER_ENTRY_S(vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p);
  localparam int entry_width_lp = $bits(bp_fe_fetch_buffer_entry_s);

  logic [ptr_width_lp-1:0]    r_wptr, r_rptr;
  logic [ptr_width_lp-1:0]    w_count;
  logic                       w_full, w_empty, w_bypass, w_enq, w_deq;
  bp_fe_fetch_buffer_entry_s  w_fetch_entry, w_head_entry, w_out_entry;

  assign w_fetch_entry.pc          = fetch_pc_i;
  assign w_fetch_entry.instr       = fetch_instr_i;
  assign w_fetch_entry.br_metadata = fetch_br_metadata_i;

  // The extra wrap bit makes the plain difference distinguish full from empty.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == ptr_width_lp'(els_p));
  assign w_empty = (w_count == '0);

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
  assign w_bypass    = w_empty & fetch_v_i & ~flush_i;
  assign w_out_entry = w_bypass ? w_fetch_entry : w_head_entry;
`else
  assign w_bypass    = 1'b0;
  assign w_out_entry = w_head_entry;
`endif

  // A bypassed packet consumed in the same cycle never touches storage.
  assign w_enq = fetch_v_i & ~flush_i & ~w_full & ~(w_bypass & fe_yumi_i);
  assign w_deq = fe_yumi_i & ~flush_i & ~w_empty;

  assign replay_v_o       = fetch_v_i & ~flush_i & w_full;
  assign fe_v_o           = ~w_empty | w_bypass;
  assign fe_pc_o          = w_out_entry.pc;
  assign fe_instr_o       = w_out_entry.instr;
  assign fe_br_metadata_o = w_out_entry.br_metadata;
  assign count_o          = count_width_lp'(w_count);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
    end
  end

  bp_fe_fetch_buffer_mem #(
    .els_p   (els_p),
    .width_p (entry_width_lp)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (w_enq),
    .w_addr_i (r_wptr[addr_width_lp-1:0]),
    .w_data_i (w_fetch_entry),
    .r_addr_i (r_rptr[addr_width_lp-1:0]),
    .r_data_o (w_head_entry)
  );

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) fe_yumi_i |-> fe_v_o);
`endif

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Bench for bp_fe_fetch_buffer: queue-based reference model plus directed and random fetch/yumi/flush traffic.
module tb_bp_fe_fetch_buffer;
  localparam int VA  = 39;
  localparam int IW  = 32;
  localparam int MW  = 36;
  localparam int ELS = 4;

  typedef struct packed {
    logic [VA-1:0] pc;
    logic [IW-1:0] instr;
    logic [MW-1:0] md;
  } pkt_t;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          fetch_v_i;
  logic [VA-1:0] fetch_pc_i;
  logic [IW-1:0] fetch_instr_i;
  logic [MW-1:0] fetch_br_metadata_i;
  logic          replay_v_o;
  logic          flush_i;
  logic          fe_v_o;
  logic [VA-1:0] fe_pc_o;
  logic [IW-1:0] fe_instr_o;
  logic [MW-1:0] fe_br_metadata_o;
  logic          fe_yumi_i;
  logic [2:0]    count_o;

  bp_fe_fetch_buffer #(
    .vaddr_width_p(VA), .instr_width_p(IW), .branch_metadata_fwd_width_p(MW), .els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
    .fetch_br_metadata_i(fetch_br_metadata_i), .replay_v_o(replay_v_o), .flush_i(flush_i),
    .fe_v_o(fe_v_o), .fe_pc_o(fe_pc_o), .fe_instr_o(fe_instr_o), .fe_br_metadata_o(fe_br_metadata_o),
    .fe_yumi_i(fe_yumi_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  pkt_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit bypass_now();
    bit b = 1'b0;
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    b = (q.size() == 0) && fetch_v_i && !flush_i;
`endif
    return b;
  endfunction

  function automatic bit fe_v_expected();
    return (q.size() > 0) || bypass_now();
  endfunction

  task automatic drive(bit fv, logic [VA-1:0] pc, bit fl, bit y);
    fetch_v_i           = fv;
    fetch_pc_i          = pc;
    fetch_instr_i       = {pc[29:0], 2'b11};
    fetch_br_metadata_i = {pc[35:0]} ^ 36'hA_5A5A_5A5A;
    flush_i             = fl;
    fe_yumi_i           = y;
  endtask

  // Check every output against the queue model mid-cycle, then advance the model across the edge.
  task automatic tick();
    int   cnt;
    bit   full, byp, ev;
    pkt_t inp, head;
    @(negedge clk_i);
    cnt  = q.size();
    full = (cnt == ELS);
    byp  = bypass_now();
    ev   = (cnt > 0) || byp;
    inp  = '{pc: fetch_pc_i, instr: fetch_instr_i, md: fetch_br_metadata_i};
    head = (cnt > 0) ? q[0] : inp;
    chk("fe_v", fe_v_o, ev);
    chk("count", count_o, cnt);
    chk("replay", replay_v_o, fetch_v_i && !flush_i && full);
    if (ev) begin
      chk("fe_pc", fe_pc_o, head.pc);
      chk("fe_instr", fe_instr_o, head.instr);
      chk("fe_md", fe_br_metadata_o, head.md);
    end
    if (flush_i) q.delete();
    else begin
      if (fe_yumi_i && cnt > 0) void'(q.pop_front());
      if (fetch_v_i && !full && !(byp && fe_yumi_i)) q.push_back(inp);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(0, '0, 0, 0);
    #2;
    chk("reset_fe_v", fe_v_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_replay", replay_v_o, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    tick();

    // First packet after reset
    drive(1, 39'h80000000, 0, 0);
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    #1;
    chk("first_bypass_v", fe_v_o, 1);
    chk("first_bypass_pc", fe_pc_o, 39'h80000000);
`endif
    tick();
    drive(0, '0, 0, 0);
    #1;
    chk("first_v", fe_v_o, 1);
    chk("first_pc", fe_pc_o, 39'h80000000);
    chk("first_count", count_o, 1);
    drive(0, '0, 0, 1);
    tick();

    // Fill, replay on the fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 39'h100 + 39'(4*i), 0, 0);
      tick();
    end
    drive(1, 39'h110, 0, 0);
    #1;
    chk("full_replay", replay_v_o, 1);
    tick();
    drive(0, '0, 0, 0);
    #1;
    chk("full_count", count_o, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, 1);
      #1;
      chk("drain_pc", fe_pc_o, 39'h100 + 39'(4*i));
      tick();
    end
    chk("drained_count", count_o, 0);

    // Full with same-cycle yumi: still replays, then accepted next cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 39'h200 + 39'(4*i), 0, 0);
      tick();
    end
    drive(1, 39'h210, 0, 1);
    #1;
    chk("full_yumi_replay", replay_v_o, 1);
    tick();
    chk("full_yumi_count", count_o, 3);
    drive(1, 39'h210, 0, 0);
    #1;
    chk("refetch_no_replay", replay_v_o, 0);
    tick();
    chk("refetch_count", count_o, 4);
    drive(0, '0, 0, 1);
    tick();
    chk("pre_flush_count", count_o, 3);

    // Flush beats same-cycle fetch and yumi
    drive(1, 39'h300, 1, 1);
    #1;
    chk("flush_replay", replay_v_o, 0);
    tick();
    drive(0, '0, 0, 0);
    #1;
    chk("flush_count", count_o, 0);
    chk("flush_fe_v", fe_v_o, 0);

    // Streaming across pointer wrap
    drive(1, 39'h1000, 0, 0);
    tick();
    for (int i = 1; i < 20; i++) begin
      drive(1, 39'h1000 + 39'(4*i), 0, 1);
      tick();
      chk("stream_count", count_o, 1);
    end
    drive(0, '0, 0, 1);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, {7'h0, $urandom()}, $urandom_range(0, 31) == 0, 0);
      fe_yumi_i = fe_v_expected() && ($urandom_range(0, 2) != 0);
      tick();
    end

    // Asynchronous reset with two packets held
    drive(0, '0, 1, 0);
    tick();
    drive(1, 39'h500, 0, 0);
    tick();
    drive(1, 39'h504, 0, 0);
    tick();
    drive(0, '0, 0, 0);
    #1;
    chk("pre_reset_count", count_o, 2);
    reset_i = 1'b1;
    #1;
    chk("async_reset_fe_v", fe_v_o, 0);
    chk("async_reset_count", count_o, 0);
    q.delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
